// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: shares the single Registers write port between two
// writeback requesters (port 0 = ALU, port 1 = memory load).
// Each port owns a one-entry holding buffer; a registered output stage
// drives RegWr/Rw/data_in so the register file sees stable values at its
// falling-edge write. Same-register writes always issue in acceptance order.
// Optional build macro: WB_RR_EN selects round-robin priority for
// different-register conflicts (default build is fixed priority, port 1 wins).
module reg_wb_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb0_valid,
    output logic             wb0_ready,
    input  logic [4:0]       wb0_rw,
    input  logic [31:0]      wb0_data,
    input  logic             wb1_valid,
    output logic             wb1_ready,
    input  logic [4:0]       wb1_rw,
    input  logic [31:0]      wb1_data,
    output logic             RegWr,
    output logic [4:0]       Rw,
    output logic [31:0]      data_in,
    input  logic [4:0]       hz_ra,
    input  logic [4:0]       hz_rb,
    output logic             hz_busy_a,
    output logic             hz_busy_b,
    output logic [CNT_W-1:0] wr_count
);

    logic        full0;
    logic [4:0]  rw0_q;
    logic [31:0] data0_q;
    logic        full1;
    logic [4:0]  rw1_q;
    logic [31:0] data1_q;
    logic        old1;

    logic        grant0;
    logic        grant1;
    logic        any_grant;
    logic        conflict;
    logic        xfer0;
    logic        xfer1;
    logic [4:0]  sel_rw;
    logic [31:0] sel_data;

`ifdef WB_RR_EN
    logic        rr_ptr;
`endif

    // Pick which buffer drains this cycle: age decides same-register pairs
    // so writes to one register never reorder; otherwise priority decides.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (full0 && full1) begin
            if (rw0_q == rw1_q) begin
                grant1 = old1;
                grant0 = !old1;
            end else begin
`ifdef WB_RR_EN
                grant0 = !rr_ptr;
                grant1 = rr_ptr;
`else
                grant1 = 1'b1;
`endif
            end
        end else begin
            grant0 = full0;
            grant1 = full1;
        end
    end

    assign conflict  = full0 && full1 && (rw0_q != rw1_q);
    assign any_grant = grant0 || grant1;
    assign sel_rw    = grant1 ? rw1_q : rw0_q;
    assign sel_data  = grant1 ? data1_q : data0_q;

    // A port may refill its buffer on the same edge the old entry drains,
    // which is what lets an uncontended port stream one write per cycle.
    assign wb0_ready = rst_n && (!full0 || grant0);
    assign wb1_ready = rst_n && (!full1 || grant1);
    assign xfer0     = wb0_valid && wb0_ready;
    assign xfer1     = wb1_valid && wb1_ready;

    // Hazard lookup covers both holding buffers and the write in flight
    // at the output register; register 0 is never a hazard.
    assign hz_busy_a = (hz_ra != 5'd0) &&
                       ((full0 && (rw0_q == hz_ra)) ||
                        (full1 && (rw1_q == hz_ra)) ||
                        (RegWr && (Rw == hz_ra)));
    assign hz_busy_b = (hz_rb != 5'd0) &&
                       ((full0 && (rw0_q == hz_rb)) ||
                        (full1 && (rw1_q == hz_rb)) ||
                        (RegWr && (Rw == hz_rb)));

    // Port 0 holding buffer: capture on transfer, clear once granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full0   <= 1'b0;
            rw0_q   <= 5'd0;
            data0_q <= 32'd0;
        end else if (xfer0) begin
            full0   <= 1'b1;
            rw0_q   <= wb0_rw;
            data0_q <= wb0_data;
        end else if (grant0) begin
            full0   <= 1'b0;
        end
    end

    // Port 1 holding buffer: capture on transfer, clear once granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full1   <= 1'b0;
            rw1_q   <= 5'd0;
            data1_q <= 32'd0;
        end else if (xfer1) begin
            full1   <= 1'b1;
            rw1_q   <= wb1_rw;
            data1_q <= wb1_data;
        end else if (grant1) begin
            full1   <= 1'b0;
        end
    end

    // Track which buffer holds the older entry; a buffer that stays full
    // while the other one captures is the older of the two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            old1 <= 1'b0;
        end else if (xfer0 && xfer1) begin
            old1 <= 1'b1;
        end else if (xfer1 && full0 && !grant0) begin
            old1 <= 1'b0;
        end else if (xfer0 && full1 && !grant1) begin
            old1 <= 1'b1;
        end
    end

    // Registered output stage; register-0 writes are consumed silently
    // and idle cycles keep the last address/data on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWr   <= 1'b0;
            Rw      <= 5'd0;
            data_in <= 32'd0;
        end else if (any_grant) begin
            RegWr   <= (sel_rw != 5'd0);
            Rw      <= sel_rw;
            data_in <= sel_data;
        end else begin
            RegWr   <= 1'b0;
        end
    end

    // Count every real register-file write; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (any_grant && (sel_rw != 5'd0)) begin
            wr_count <= wr_count + CNT_W'(1);
        end
    end

`ifdef WB_RR_EN
    // Round-robin pointer moves only on different-register conflicts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (conflict) begin
            rr_ptr <= !rr_ptr;
        end
    end
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed self-checking bench for reg_wb_arbiter.
// Expected writes are queued as each scenario is driven and popped by a
// monitor whenever the output stage issues RegWr.
// Build with WB_RR_EN defined to exercise the round-robin conflict sequence.
module tb_reg_wb_arbiter;

`ifdef WB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        wb0_valid;
    logic        wb0_ready;
    logic [4:0]  wb0_rw;
    logic [31:0] wb0_data;
    logic        wb1_valid;
    logic        wb1_ready;
    logic [4:0]  wb1_rw;
    logic [31:0] wb1_data;
    logic        RegWr;
    logic [4:0]  Rw;
    logic [31:0] data_in;
    logic [4:0]  hz_ra;
    logic [4:0]  hz_rb;
    logic        hz_busy_a;
    logic        hz_busy_b;
    logic [15:0] wr_count;

    int checks   = 0;
    int failures = 0;

    logic [36:0] exp_q[$];
    logic [31:0] tb_regs [32];

    reg_wb_arbiter #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb0_valid (wb0_valid),
        .wb0_ready (wb0_ready),
        .wb0_rw    (wb0_rw),
        .wb0_data  (wb0_data),
        .wb1_valid (wb1_valid),
        .wb1_ready (wb1_ready),
        .wb1_rw    (wb1_rw),
        .wb1_data  (wb1_data),
        .RegWr     (RegWr),
        .Rw        (Rw),
        .data_in   (data_in),
        .hz_ra     (hz_ra),
        .hz_rb     (hz_rb),
        .hz_busy_a (hz_busy_a),
        .hz_busy_b (hz_busy_b),
        .wr_count  (wr_count)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present both request ports for one rising edge, then settle 1 ns past it.
    task automatic applyStimulus(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        wb0_valid = v0;
        wb0_rw    = r0;
        wb0_data  = d0;
        wb1_valid = v1;
        wb1_rw    = r1;
        wb1_data  = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic expectWrite(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back({r, d});
    endtask

    // Scoreboard monitor: every issued write must match the queue head.
    initial begin
        logic [36:0] head;
        forever begin
            @(negedge clk);
            if (RegWr === 1'b1) begin
                tb_regs[Rw] = data_in;
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_regwr", {63'd0, RegWr}, 64'd0);
                end else begin
                    head = exp_q.pop_front();
                    checkOutput("issue_rw", {59'd0, Rw}, {59'd0, head[36:32]});
                    checkOutput("issue_data", {32'd0, data_in}, {32'd0, head[31:0]});
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenario sequence.
    initial begin
        for (int i = 0; i < 32; i++) tb_regs[i] = 32'd0;
        rst_n     = 1'b0;
        wb0_valid = 1'b0;
        wb0_rw    = 5'd0;
        wb0_data  = 32'd0;
        wb1_valid = 1'b0;
        wb1_rw    = 5'd0;
        wb1_data  = 32'd0;
        hz_ra     = 5'd5;
        hz_rb     = 5'd9;

        // Reset values while rst_n is low.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_regwr", {63'd0, RegWr}, 64'd0);
        checkOutput("rst_rw", {59'd0, Rw}, 64'd0);
        checkOutput("rst_data", {32'd0, data_in}, 64'd0);
        checkOutput("rst_count", {48'd0, wr_count}, 64'd0);
        checkOutput("rst_ready0", {63'd0, wb0_ready}, 64'd0);
        checkOutput("rst_ready1", {63'd0, wb1_ready}, 64'd0);
        checkOutput("rst_hz_a", {63'd0, hz_busy_a}, 64'd0);
        rst_n = 1'b1;
        idleCycles(1);
        checkOutput("idle_ready0", {63'd0, wb0_ready}, 64'd1);
        checkOutput("idle_ready1", {63'd0, wb1_ready}, 64'd1);
        checkOutput("idle_regwr", {63'd0, RegWr}, 64'd0);

        // Single uncontended write r5 = 0x1234 from port 0.
        expectWrite(5'd5, 32'h1234);
        applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        checkOutput("s1_hz_buf", {63'd0, hz_busy_a}, 64'd1);
        checkOutput("s1_ready0", {63'd0, wb0_ready}, 64'd1);
        idleCycles(1);
        checkOutput("s1_regwr", {63'd0, RegWr}, 64'd1);
        checkOutput("s1_rw", {59'd0, Rw}, 64'd5);
        checkOutput("s1_data", {32'd0, data_in}, 64'h1234);
        checkOutput("s1_count", {48'd0, wr_count}, 64'd1);
        checkOutput("s1_hz_out", {63'd0, hz_busy_a}, 64'd1);
        idleCycles(1);
        checkOutput("s1_regwr_off", {63'd0, RegWr}, 64'd0);
        checkOutput("s1_hz_clear", {63'd0, hz_busy_a}, 64'd0);

        // Both ports on one edge with different registers.
        if (RR_MODE) begin
            expectWrite(5'd3, 32'hA);
            expectWrite(5'd7, 32'hB);
        end else begin
            expectWrite(5'd7, 32'hB);
            expectWrite(5'd3, 32'hA);
        end
        applyStimulus(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
        checkOutput("s2_ready0_stall", {63'd0, wb0_ready}, {63'd0, RR_MODE});
        checkOutput("s2_ready1", {63'd0, wb1_ready}, {63'd0, !RR_MODE});
        idleCycles(1);
        checkOutput("s2_ready0_back", {63'd0, wb0_ready}, 64'd1);
        idleCycles(2);
        checkOutput("s2_count", {48'd0, wr_count}, 64'd3);
        checkOutput("s2_drained", 64'(exp_q.size()), 64'd0);

        // Age ordering on r9 while buffer 0 is stalled behind port 1.
        expectWrite(5'd4, 32'h44);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
        expectWrite(5'd6, 32'h66);
        expectWrite(5'd9, 32'h1);
        applyStimulus(1'b1, 5'd9, 32'h1, 1'b1, 5'd6, 32'h66);
        checkOutput("s3_ready0_stall", {63'd0, wb0_ready}, 64'd0);
        checkOutput("s3_ready1", {63'd0, wb1_ready}, 64'd1);
        expectWrite(5'd9, 32'h2);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h2);
        checkOutput("s3_old_ready0", {63'd0, wb0_ready}, 64'd1);
        checkOutput("s3_young_ready1", {63'd0, wb1_ready}, 64'd0);
        checkOutput("s3_hz_b", {63'd0, hz_busy_b}, 64'd1);
        idleCycles(3);
        checkOutput("s3_r9_final", {32'd0, tb_regs[9]}, 64'h2);
        checkOutput("s3_count", {48'd0, wr_count}, 64'd7);
        checkOutput("s3_drained", 64'(exp_q.size()), 64'd0);

        // Register-0 write is accepted but never reaches the register file.
        hz_ra = 5'd0;
        applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
        checkOutput("s4_hz_r0", {63'd0, hz_busy_a}, 64'd0);
        idleCycles(1);
        checkOutput("s4_regwr", {63'd0, RegWr}, 64'd0);
        checkOutput("s4_count", {48'd0, wr_count}, 64'd7);
        idleCycles(1);

        // Reset with both buffers full: nothing may issue afterwards.
        hz_ra = 5'd10;
        applyStimulus(1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB);
        checkOutput("s5_hz_before", {63'd0, hz_busy_a}, 64'd1);
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        checkOutput("s5_regwr", {63'd0, RegWr}, 64'd0);
        checkOutput("s5_ready0", {63'd0, wb0_ready}, 64'd0);
        checkOutput("s5_hz_flush", {63'd0, hz_busy_a}, 64'd0);
        checkOutput("s5_count", {48'd0, wr_count}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(4);
        checkOutput("s5_count_after", {48'd0, wr_count}, 64'd0);

`ifdef WB_RR_EN
        // Four back-to-back different-register conflicts: grants 0,1,0,1.
        expectWrite(5'd1, 32'h10);
        expectWrite(5'd2, 32'h20);
        expectWrite(5'd3, 32'h30);
        expectWrite(5'd4, 32'h40);
        expectWrite(5'd5, 32'h50);
        applyStimulus(1'b1, 5'd1, 32'h10, 1'b1, 5'd2, 32'h20);
        checkOutput("rr_first_ready0", {63'd0, wb0_ready}, 64'd1);
        applyStimulus(1'b1, 5'd3, 32'h30, 1'b0, 5'd0, 32'd0);
        checkOutput("rr_second_ready1", {63'd0, wb1_ready}, 64'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h40);
        checkOutput("rr_third_ready0", {63'd0, wb0_ready}, 64'd1);
        applyStimulus(1'b1, 5'd5, 32'h50, 1'b0, 5'd0, 32'd0);
        checkOutput("rr_fourth_ready1", {63'd0, wb1_ready}, 64'd1);
        idleCycles(4);
        checkOutput("rr_count", {48'd0, wr_count}, 64'd5);
        checkOutput("rr_drained", 64'(exp_q.size()), 64'd0);
`endif

        idleCycles(2);
        checkOutput("final_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

- Shares the single write port of `Registers` between two writeback requesters: port 0 (ALU result) and port 1 (memory load).
- Buffers one pending write per port and arbitrates between them, with same-register ordering protection.
- Drives `RegWr`/`Rw`/`data_in` from a registered output stage, so `Registers` samples stable values on its falling-edge write.
- Provides hazard flags for two read addresses so the issue stage can stall on pending writes.

## Interface
Parameters:
- `CNT_W`, 16, width of the committed-write statistics counter.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wb0_valid`  in  1  port 0 request valid.
- `wb0_ready`  out  1  port 0 can accept this cycle.
- `wb0_rw`  in  5  port 0 destination register.
- `wb0_data`  in  32  port 0 write data.
- `wb1_valid`, `wb1_ready`, `wb1_rw`, `wb1_data`  same as port 0, for port 1.
- `RegWr`  out  1  register-file write enable (registered).
- `Rw`  out  5  register-file write address (registered).
- `data_in`  out  32  register-file write data (registered).
- `hz_ra`, `hz_rb`  in  5 each  read addresses to check.
- `hz_busy_a`, `hz_busy_b`  out  1 each  pending write to `hz_ra` / `hz_rb`.
- `wr_count`  out  CNT_W  count of committed nonzero-address writes.

## Operation
State:
- Per-port holding buffer: full flag, rw, data.
- One age bit, `old1`, meaning buffer 1 is older than buffer 0.
- Output register: `RegWr`, `Rw`, `data_in`.
- Arbitration pointer, used only with the round-robin configuration.
- `wr_count`.

Handshake:
- `wbN_ready = !fullN || grantN`.
- A transfer occurs on a rising edge where valid and ready are both high.
- `wbN_data` and `wbN_rw` are captured on that edge.
- Valid may drop without a transfer; the request is then not stored.

Grant, evaluated each cycle:
- Neither buffer full: no grant. `RegWr` is 0 on the next edge; `Rw` and `data_in` hold their values.
- Exactly one buffer full: that buffer is granted.
- Both full with equal rw: the older buffer wins, regardless of priority mode.
- Both full with different rw: port 1 wins (fixed priority), unless `WB_RR_EN` is defined.

On each edge:
- The granted buffer moves to the output register and clears, unless it is refilled by a transfer on the same edge.
- The output register loads `RegWr = (rw != 0)`.
- A granted write with rw == 0 is consumed and discarded: `RegWr` = 0 and `wr_count` is unchanged.
- `wr_count` increments on every edge that loads `RegWr` = 1, wrapping at 2^CNT_W.

Age tracking:
- Capture into one buffer while the other is full and not being granted: the other buffer becomes older.
- Both ports capture on the same edge into empty buffers: buffer 1 is older.

Hazard flags:
- `hz_busy_a` = `hz_ra != 0` AND (buffer 0 holds `hz_ra`, OR buffer 1 holds `hz_ra`, OR `RegWr` = 1 with `Rw == hz_ra`).
- `hz_busy_b` follows the same rule using `hz_rb`.
- Both flags are combinational.

## Timing
- Reset values while `rst_n` is low:
  - Buffers empty; `old1` = 0; pointer = port 0.
  - `RegWr` = 0, `Rw` = 0, `data_in` = 0, `wr_count` = 0.
  - `wbN_ready` = 0, `hz_busy_*` = 0.
- Reset asserted mid-transfer discards all buffered writes; no write is issued after reset.
- Latency:
  - Request accepted at edge N appears on `RegWr`/`Rw`/`data_in` after edge N+1 if uncontended.
  - `Registers` commits it at the falling edge of that cycle.
- Throughput: one write per cycle aggregate. An uncontended port sustains back-to-back transfers because ready is high while its buffer is being granted.
- A losing port holds its buffer with ready low until it is granted.

## Configuration
- `WB_RR_EN` defined: round-robin priority on different-rw conflicts.
  - After reset, port 0 wins the first conflict.
  - The pointer flips to the other port after each conflict grant.
  - Same-rw conflicts are still resolved by age and do not move the pointer.
- `WB_RR_EN` undefined: fixed priority, port 1 always wins different-rw conflicts; no pointer register exists.

## Test plan
- Reset then idle: `RegWr`=0, `Rw`=0, `data_in`=0, `wr_count`=0; both ready =1 after `rst_n` rises.
- Port 0 writes r5=0x1234 at edge N: `RegWr`=1, `Rw`=5, `data_in`=0x1234 after N+1; `wr_count`=1; `hz_busy_a` with `hz_ra`=5 is high from after N until the cycle after the write leaves the output register.
- Both ports accepted on the same edge with r3=0xA (port 0) and r7=0xB (port 1), fixed mode: r7 is issued first, then r3; `wb0_ready` is 0 for one cycle.
- Age ordering:
  - Stimulus: port 0 r9=0x1 is accepted while port 1 is blocked; port 1 r9=0x2 is accepted next edge while buffer 0 is still stalled (hold one more request in buffer 1 first).
  - Required: the writes issue in acceptance order and the final value of r9 is 0x2.
- rw=0 write of 0xFFFF: accepted, `RegWr` stays 0, `wr_count` unchanged, `hz_busy_a` with `hz_ra`=0 stays low.
- `WB_RR_EN`, four consecutive different-rw conflicts: grants go 0,1,0,1. Separately, assert `rst_n` low with both buffers full: no further `RegWr` pulse occurs.
